// File: rtl/data_width_packer.sv
// Byte-stream to 1/2/4/8/16-bit lane packer: byte FIFO, slicing shifter and a
// registered valid/ready output stage. Lane width changes only when fully drained.
module data_width_packer #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    data_form,
    input  logic          flush,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [15:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   fifo_usedw,
    output logic          mode_busy
);

    typedef enum logic [2:0] {
        MODE_1B, MODE_2B, MODE_4B, MODE_8B, MODE_16B
    } mode_e;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    function automatic mode_e decode_mode(input logic [3:0] f);
        case (f)
            4'd1:    return MODE_1B;
            4'd2:    return MODE_2B;
            4'd3:    return MODE_4B;
            4'd5:    return MODE_16B;
            default: return MODE_8B;
        endcase
    endfunction

    // Read side is asynchronous: the shifter may pull two bytes in the same cycle
    // a byte becomes visible, which the two-cycle latency budget depends on.
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_p1;
    logic [AW:0]   usedw_q, usedw_d, rd_cnt;
    logic          in_ready_q;
    logic [15:0]   sh_data_q, sh_shifted, slice;
    logic [3:0]    sh_cnt_q, slice_w, beats;
    logic [15:0]   out_data_q;
    logic          out_valid_q;
    mode_e         mode_q;

    logic is_16b, out_ld, take, sh_free, sh_load, wr_en, idle;

    always_comb begin
        slice_w = 4'd8;
        beats   = 4'd1;
        case (mode_q)
            MODE_1B:  begin slice_w = 4'd1; beats = 4'd8; end
            MODE_2B:  begin slice_w = 4'd2; beats = 4'd4; end
            MODE_4B:  begin slice_w = 4'd4; beats = 4'd2; end
            default:  begin slice_w = 4'd8; beats = 4'd1; end
        endcase
    end

    assign is_16b     = (mode_q == MODE_16B);
    assign rd_ptr_p1  = rd_ptr_q + AW'(1);
    // Sub-byte lanes leave MSB-first from the low byte of the shifter.
    assign slice      = is_16b ? sh_data_q
                               : {8'd0, sh_data_q[7:0] >> (4'd8 - slice_w)};
    assign sh_shifted = {8'd0, sh_data_q[7:0] << slice_w};

    assign out_ld  = !out_valid_q || out_ready;
    assign take    = out_ld && (sh_cnt_q != 4'd0);
    assign sh_free = (sh_cnt_q == 4'd0) || (take && (sh_cnt_q == 4'd1));
    assign sh_load = sh_free && (is_16b ? (usedw_q >= (AW+1)'(2)) : (usedw_q != '0));
    assign rd_cnt  = sh_load ? (is_16b ? (AW+1)'(2) : (AW+1)'(1)) : '0;
    assign wr_en   = in_valid && in_ready_q;
    assign usedw_d = usedw_q + (AW+1)'(wr_en) - rd_cnt;
    assign idle    = (usedw_q == '0) && (sh_cnt_q == 4'd0) && !out_valid_q;

    always_ff @(posedge clk) begin
        if (wr_en && !rst && !flush)
            mem[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            usedw_q     <= '0;
            in_ready_q  <= !rst;
            sh_data_q   <= '0;
            sh_cnt_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            // After a flush the block is idle, so the requested mode applies at once.
            mode_q      <= rst ? MODE_8B : decode_mode(data_form);
        end else begin
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (sh_load)
                rd_ptr_q <= is_16b ? rd_ptr_q + AW'(2) : rd_ptr_p1;
            usedw_q    <= usedw_d;
            in_ready_q <= (usedw_d != FULL_LVL);
            if (idle)
                mode_q <= decode_mode(data_form);

            if (sh_load) begin
                sh_data_q <= is_16b ? {mem[rd_ptr_q], mem[rd_ptr_p1]} : {8'd0, mem[rd_ptr_q]};
                sh_cnt_q  <= beats;
            end else if (take) begin
                sh_data_q <= sh_shifted;
                sh_cnt_q  <= sh_cnt_q - 4'd1;
            end

            if (take) begin
                out_data_q  <= slice;
                out_valid_q <= 1'b1;
            end else if (out_ld) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign fifo_usedw = usedw_q;
    assign mode_busy  = !idle;

endmodule
